// File: rtl/ddr_burst_sched.sv
// Burst scheduler between the AD FIFO, a circular DDR region and the wavelet FIFO.
// Define DDR_SCHED_STAT_EN to add the wr_burst_cnt / rd_burst_cnt statistics outputs.
module ddr_burst_sched #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 25,
    parameter int unsigned BURST_LEN    = 128,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned REGION_WORDS = 2**24,
    parameter int unsigned FIFO_CNT_W   = 11
) (
    input  logic                    mem_clk,
    input  logic                    rst_n,
    input  logic                    local_init_done,
    input  logic [FIFO_CNT_W-1:0]   ad_fifo_usedw,
    input  logic [DATA_WIDTH-1:0]   ad_fifo_q,
    output logic                    ad_fifo_rdreq,
    input  logic [FIFO_CNT_W-1:0]   wav_fifo_free,
    output logic                    wav_fifo_wrreq,
    output logic [DATA_WIDTH-1:0]   wav_fifo_data,
    output logic                    wr_burst_req,
    output logic [9:0]              wr_burst_len,
    output logic [ADDR_WIDTH-1:0]   wr_burst_addr,
    input  logic                    wr_burst_data_req,
    output logic [DATA_WIDTH-1:0]   wr_burst_data,
    input  logic                    wr_burst_finish,
    output logic                    rd_burst_req,
    output logic [9:0]              rd_burst_len,
    output logic [ADDR_WIDTH-1:0]   rd_burst_addr,
    input  logic                    rd_burst_data_valid,
    input  logic [DATA_WIDTH-1:0]   rd_burst_data,
    input  logic                    rd_burst_finish,
    output logic [ADDR_WIDTH:0]     fill_level,
    output logic                    overflow
`ifdef DDR_SCHED_STAT_EN
    ,
    output logic [31:0]             wr_burst_cnt,
    output logic [31:0]             rd_burst_cnt
`endif
);

    localparam int unsigned FILL_W = ADDR_WIDTH + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;

    localparam logic [FILL_W-1:0]     BURST_F  = FILL_W'(BURST_LEN);
    localparam logic [FILL_W-1:0]     REGION_F = FILL_W'(REGION_WORDS);
    localparam logic [FILL_W-1:0]     WR_LIMIT = FILL_W'(REGION_WORDS - BURST_LEN);
    localparam logic [FIFO_CNT_W-1:0] BURST_C  = FIFO_CNT_W'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_turn;
    logic                  ad_ready;
    logic                  room_ok;
    logic                  can_wr;
    logic                  can_rd;
    logic                  ovf_set;
    logic                  launch_wr;
    logic                  launch_rd;
    logic                  wr_done;
    logic                  rd_done;

    assign wr_burst_len = 10'(BURST_LEN);
    assign rd_burst_len = 10'(BURST_LEN);

    assign ad_ready  = (ad_fifo_usedw >= BURST_C);
    assign room_ok   = (fill_level <= WR_LIMIT);
    assign can_wr    = ad_ready && room_ok;
    assign can_rd    = (fill_level >= BURST_F) && (wav_fifo_free >= BURST_C);
    assign launch_wr = (state == S_IDLE) && (state_nxt == S_WR);
    assign launch_rd = (state == S_IDLE) && (state_nxt == S_RD);
    assign wr_done   = (state == S_WR) && wr_burst_finish;
    assign rd_done   = (state == S_RD) && rd_burst_finish;

    // Advance a region pointer by one burst, wrapping at the region end.
    function automatic logic [ADDR_WIDTH-1:0] ptr_step(input logic [ADDR_WIDTH-1:0] p);
        logic [FILL_W-1:0] s;
        s = {1'b0, p} + BURST_F;
        return (s >= REGION_F) ? '0 : ADDR_WIDTH'(s);
    endfunction

    // State register
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, burst arbitration and the write data pass-through
    always_comb begin
        state_nxt     = state;
        ovf_set       = 1'b0;
        ad_fifo_rdreq = 1'b0;
        wr_burst_data = '0;
        case (state)
            S_IDLE: begin
                if (local_init_done) begin
                    if (can_wr && can_rd) begin
                        state_nxt = wr_turn ? S_WR : S_RD;
                    end else if (can_wr) begin
                        state_nxt = S_WR;
                    end else if (can_rd) begin
                        state_nxt = S_RD;
                    end
                    ovf_set = ad_ready && !room_ok;
                end
            end
            S_WR: begin
                ad_fifo_rdreq = wr_burst_data_req;
                wr_burst_data = ad_fifo_q;
                if (wr_burst_finish) begin
                    state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: state_nxt = S_IDLE;
            S_RD: begin
                if (rd_burst_finish) begin
                    state_nxt = S_RD_WAIT;
                end
            end
            S_RD_WAIT: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Requests, addresses, pointers and fill level
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_burst_req  <= 1'b0;
            rd_burst_req  <= 1'b0;
            wr_burst_addr <= '0;
            rd_burst_addr <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            wr_turn       <= 1'b1;
            overflow      <= 1'b0;
        end else begin
            wr_burst_req <= (state_nxt == S_WR);
            rd_burst_req <= (state_nxt == S_RD);
            if (launch_wr) begin
                wr_burst_addr <= BASE_A + wr_ptr;
                wr_turn       <= 1'b0;
            end
            if (launch_rd) begin
                rd_burst_addr <= BASE_A + rd_ptr;
                wr_turn       <= 1'b1;
            end
            // Single outstanding burst: at most one finish is ever live
            if (wr_done) begin
                wr_ptr     <= ptr_step(wr_ptr);
                fill_level <= fill_level + BURST_F;
            end else if (rd_done) begin
                rd_ptr     <= ptr_step(rd_ptr);
                fill_level <= fill_level - BURST_F;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read data to the wavelet FIFO, one cycle behind the controller
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            wav_fifo_wrreq <= 1'b0;
            wav_fifo_data  <= '0;
        end else begin
            wav_fifo_wrreq <= (state == S_RD) && rd_burst_data_valid;
            if ((state == S_RD) && rd_burst_data_valid) begin
                wav_fifo_data <= rd_burst_data;
            end
        end
    end

`ifdef DDR_SCHED_STAT_EN
    // Completed burst counters, free-running modulo 2^32
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_burst_cnt <= '0;
            rd_burst_cnt <= '0;
        end else begin
            if (wr_done) begin
                wr_burst_cnt <= wr_burst_cnt + 32'd1;
            end
            if (rd_done) begin
                rd_burst_cnt <= rd_burst_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ddr_burst_sched.md
Name: ddr_burst_sched

Overview:
- Initiator for the DDR user burst interface; the controller wrapper is the responder.
- Moves AD samples from the AD→DDR FIFO into a circular DDR region in fixed-length write bursts.
- Reads the region back in order, with the same burst length, into the wavelet input FIFO.
- Runs entirely in the phy_clk domain exported by the DDR controller.

Parameters:
- DATA_WIDTH, 32, burst data width (bits).
- ADDR_WIDTH, 25, DDR word address width.
- BURST_LEN, 128, words per burst (1..1023). Drives wr_burst_len and rd_burst_len.
- BASE_ADDR, 0, first word address of the circular region.
- REGION_WORDS, 2**24, region size in words. Must be a multiple of BURST_LEN.
- FIFO_CNT_W, 11, width of the FIFO level inputs.

Ports:
- mem_clk  in  1  phy_clk from the DDR controller.
- rst_n  in  1  async active-low reset.
- local_init_done  in  1  DDR calibration complete.
- ad_fifo_usedw  in  FIFO_CNT_W  words held in the AD FIFO (show-ahead).
- ad_fifo_q  in  DATA_WIDTH  AD FIFO head word.
- ad_fifo_rdreq  out  1  AD FIFO pop.
- wav_fifo_free  in  FIFO_CNT_W  free words in the wavelet FIFO.
- wav_fifo_wrreq  out  1  wavelet FIFO push.
- wav_fifo_data  out  DATA_WIDTH  wavelet FIFO data.
- wr_burst_req  out  1  write burst request.
- wr_burst_len  out  10  always BURST_LEN.
- wr_burst_addr  out  ADDR_WIDTH  write burst start address.
- wr_burst_data_req  in  1  controller wants the next write word.
- wr_burst_data  out  DATA_WIDTH  write word.
- wr_burst_finish  in  1  write burst done (1-cycle pulse).
- rd_burst_req  out  1  read burst request.
- rd_burst_len  out  10  always BURST_LEN.
- rd_burst_addr  out  ADDR_WIDTH  read burst start address.
- rd_burst_data_valid  in  1  read word valid.
- rd_burst_data  in  DATA_WIDTH  read word.
- rd_burst_finish  in  1  read burst done (1-cycle pulse).
- fill_level  out  ADDR_WIDTH+1  words stored in DDR and not yet read.
- overflow  out  1  sticky flag: a write was skipped because the region was full.

Behaviour:
- Reset values: all outputs 0 except the constant lengths.
  - Pointers wr_ptr and rd_ptr = 0.
  - FSM in IDLE.
- Addressing:
  - wr_burst_addr = BASE_ADDR + wr_ptr; rd_burst_addr = BASE_ADDR + rd_ptr.
  - Both addresses are registered and stable while the matching req is high.
- FSM states: IDLE, WR, WR_WAIT, RD, RD_WAIT.
- IDLE: no action while local_init_done=0. Otherwise, evaluated each cycle:
  - can_wr = (ad_fifo_usedw >= BURST_LEN) and (fill_level <= REGION_WORDS-BURST_LEN).
  - can_rd = (fill_level >= BURST_LEN) and (wav_fifo_free >= BURST_LEN).
  - Both true: alternate, with the last-served type yielding. After reset, write wins first.
  - Only one true: take it.
  - Neither true: stay in IDLE.
  - ad_fifo_usedw >= BURST_LEN but the region is full: set overflow; no burst is issued.
- WR:
  - wr_burst_req=1 until wr_burst_finish.
  - ad_fifo_rdreq = wr_burst_data_req (combinational); wr_burst_data = ad_fifo_q.
  - On wr_burst_finish: wr_burst_req→0 the next cycle, wr_ptr += BURST_LEN (wraps to 0 at REGION_WORDS), fill_level += BURST_LEN, go to WR_WAIT.
- RD:
  - rd_burst_req=1 until rd_burst_finish.
  - wav_fifo_wrreq and wav_fifo_data are rd_burst_data_valid and rd_burst_data registered 1 cycle.
  - On rd_burst_finish: rd_ptr += BURST_LEN with wrap, fill_level -= BURST_LEN, go to RD_WAIT.
- WR_WAIT / RD_WAIT: one idle cycle, then IDLE. This guarantees the req is low for ≥1 cycle between bursts.
- A read data valid arriving in the same cycle as rd_burst_finish is still pushed.
- Only one burst is ever outstanding; fill_level is updated in exactly one place per finish.
- local_init_done dropping mid-burst: ignored until the burst finishes; gates only the next IDLE decision.
- rst_n asserted mid-burst: everything clears immediately. Data in DDR is discarded (pointers reset).
- overflow is cleared only by reset.

Optional Feature:
- Macro DDR_SCHED_STAT_EN.
- Defined: adds outputs wr_burst_cnt[31:0] and rd_burst_cnt[31:0].
  - Each increments on its finish pulse; wraps at 2^32; reset 0.
- Undefined: no such ports or logic; all other behaviour identical.

Test Plan:
- Reset, local_init_done=0, ad_fifo_usedw=500 → no req for 100 cycles; all outputs 0.
- init_done=1, usedw=128, free=0, BURST_LEN=128:
  - wr_burst_req with addr 0; exactly 128 ad_fifo_rdreq pulses.
  - After finish: fill_level=128, next wr_burst_addr=128.
- Then free=1024:
  - rd_burst_req with addr 0; 128 wav_fifo_wrreq pulses, each one cycle after the matching valid.
  - fill_level returns to 0.
- Both conditions held true continuously → bursts alternate W,R,W,R…, and req is low for ≥1 cycle between bursts.
- REGION_WORDS=256, free=0, usedw held at 128:
  - Two writes (addr 0, 128), then no further write and overflow=1.
  - With free raised: a read at addr 0 frees space, then a write at addr 0 (wrap).
- Assert rst_n low while a write burst is mid-transfer → req, pointers, fill_level and FSM return to 0/IDLE the same cycle, without waiting for the clock.
